phv_assembler: RTL and testbench

Reassembles a full PHV from the per-container ALU results of an action stage and hands it to the next stage under a valid/ready handshake. It is the return path of the action crossbar: the crossbar splits a PHV into 6B/4B/2B ALU operand vectors, and this block gathers the 24 ALU outputs plus the untouched metadata back into the PHV layout. A 2-entry buffer absorbs downstream stalls. Overflow and a PHV counter are exposed for debug.

---
 rtl/phv_assembler.sv | 96 +++++++++
 tb/tb_phv_assembler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/phv_assembler.sv
// Gathers action-stage ALU results back into a PHV and hands it
// downstream through a 2-entry buffer with valid/ready.
module phv_assembler #(
  parameter int STAGE_ID = 0,
  parameter int PHV_LEN  = 48*8+32*8+16*8+256,
  parameter int width_2B = 16,
  parameter int width_4B = 32,
  parameter int width_6B = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_out_valid,
  input  logic [width_6B*8-1:0] alu_out_6B,
  input  logic [width_4B*8-1:0] alu_out_4B,
  input  logic [width_2B*8-1:0] alu_out_2B,
  input  logic [255:0]          phv_remain_data,
  output logic                  ready_out,
  output logic [PHV_LEN-1:0]    phv_out,
  output logic                  phv_out_valid,
  input  logic                  ready_in,
  output logic [31:0]           phv_count,
  output logic                  overflow_err
);

  if (STAGE_ID < 0 ||
      PHV_LEN != 8*(width_6B+width_4B+width_2B)+256) begin : g_bad
    $error("phv_assembler: bad parameters");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state;
  logic [PHV_LEN-1:0] tail;
  logic [PHV_LEN-1:0] entry;
  logic               push;
  logic               pop;

  // Inverse of the crossbar split: 6B on top, metadata at the bottom
  assign entry = {alu_out_6B, alu_out_4B, alu_out_2B, phv_remain_data};
  assign push  = alu_out_valid & ready_out;
  assign pop   = phv_out_valid & ready_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= EMPTY;
      phv_out       <= '0;
      tail          <= '0;
      phv_out_valid <= 1'b0;
      ready_out     <= 1'b1;
      phv_count     <= '0;
      overflow_err  <= 1'b0;
    end else begin
      if (pop) phv_count <= phv_count + 32'd1;
      unique case (state)
        EMPTY: begin
          if (push) begin
            phv_out       <= entry;
            phv_out_valid <= 1'b1;
            state         <= ONE;
          end
        end
        ONE: begin
          if (push && !pop) begin
            tail      <= entry;
            ready_out <= 1'b0;
            state     <= FULL;
          end else if (pop && !push) begin
            phv_out_valid <= 1'b0;
            state         <= EMPTY;
          end else if (push && pop) begin
            phv_out <= entry;
          end
        end
        FULL: begin
          // No backpressure on the ALU path: a vector now is lost
          if (alu_out_valid) overflow_err <= 1'b1;
          if (pop) begin
            phv_out   <= tail;
            ready_out <= 1'b1;
            state     <= ONE;
          end
        end
        default: begin
          phv_out_valid <= 1'b0;
          ready_out     <= 1'b1;
          state         <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phv_assembler.sv
// Directed bench for phv_assembler: pass-through, stalls,
// overflow, back-to-back flow, counter wrap and reset.
module tb_phv_assembler;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_out_valid;
  logic [383:0]  alu_out_6B;
  logic [255:0]  alu_out_4B;
  logic [127:0]  alu_out_2B;
  logic [255:0]  phv_remain_data;
  logic          ready_out;
  logic [1023:0] phv_out;
  logic          phv_out_valid;
  logic          ready_in;
  logic [31:0]   phv_count;
  logic          overflow_err;

  int checks = 0;
  int errors = 0;

  logic [1023:0] exp_a, exp_b, exp_c;

  phv_assembler dut (
    .clk             (clk),
    .rst             (rst),
    .alu_out_valid   (alu_out_valid),
    .alu_out_6B      (alu_out_6B),
    .alu_out_4B      (alu_out_4B),
    .alu_out_2B      (alu_out_2B),
    .phv_remain_data (phv_remain_data),
    .ready_out       (ready_out),
    .phv_out         (phv_out),
    .phv_out_valid   (phv_out_valid),
    .ready_in        (ready_in),
    .phv_count       (phv_count),
    .overflow_err    (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [1023:0] got,
                     input logic [1023:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1023:0] mk(input logic [47:0] b6,
                                       input logic [31:0] b4,
                                       input logic [15:0] b2,
                                       input logic [255:0] r);
    logic [1023:0] v;
    v = '0;
    v[255:0] = r;
    for (int i = 0; i < 8; i++) begin
      v[640+48*i +: 48] = b6 + 48'(i);
      v[384+32*i +: 32] = b4 + 32'(i);
      v[256+16*i +: 16] = b2 + 16'(i);
    end
    return v;
  endfunction

  task automatic drive(input logic [47:0] b6,
                       input logic [31:0] b4,
                       input logic [15:0] b2,
                       input logic [255:0] r);
    alu_out_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      alu_out_6B[48*i +: 48] = b6 + 48'(i);
      alu_out_4B[32*i +: 32] = b4 + 32'(i);
      alu_out_2B[16*i +: 16] = b2 + 16'(i);
    end
    phv_remain_data = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alu_out_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    alu_out_valid = 1'b0;
    alu_out_6B = '0;
    alu_out_4B = '0;
    alu_out_2B = '0;
    phv_remain_data = '0;
    ready_in = 1'b0;
    @(negedge clk);
    do_reset();
    chk("rst_valid", 1024'(phv_out_valid), 1024'd0);
    chk("rst_ready", 1024'(ready_out), 1024'd1);
    chk("rst_count", 1024'(phv_count), 1024'd0);
    chk("rst_ovf", 1024'(overflow_err), 1024'd0);
    chk("rst_phv", phv_out, 1024'd0);

    // single pass-through
    ready_in = 1'b1;
    drive(48'h600, 32'h400, 16'h200, 256'hABCD);
    @(negedge clk);
    alu_out_valid = 1'b0;
    chk("pt_top", 1024'(phv_out[1023:976]), 1024'h607);
    chk("pt_meta", 1024'(phv_out[255:0]), 1024'hABCD);
    chk("pt_full", phv_out, mk(48'h600, 32'h400, 16'h200, 256'hABCD));
    chk("pt_valid", 1024'(phv_out_valid), 1024'd1);
    @(negedge clk);
    chk("pt_count", 1024'(phv_count), 1024'd1);
    chk("pt_empty", 1024'(phv_out_valid), 1024'd0);

    // back-pressure
    ready_in = 1'b0;
    exp_a = mk(48'h1000, 32'h2000, 16'h3000, 256'h1);
    exp_b = mk(48'h1100, 32'h2100, 16'h3100, 256'h2);
    drive(48'h1000, 32'h2000, 16'h3000, 256'h1);
    @(negedge clk);
    drive(48'h1100, 32'h2100, 16'h3100, 256'h2);
    @(negedge clk);
    alu_out_valid = 1'b0;
    chk("bp_ready", 1024'(ready_out), 1024'd0);
    chk("bp_head", phv_out, exp_a);
    @(negedge clk);
    chk("bp_stable", phv_out, exp_a);
    chk("bp_vld", 1024'(phv_out_valid), 1024'd1);
    ready_in = 1'b1;
    @(negedge clk);
    chk("bp_b", phv_out, exp_b);
    chk("bp_rdy1", 1024'(ready_out), 1024'd1);
    @(negedge clk);
    chk("bp_drain", 1024'(phv_out_valid), 1024'd0);
    chk("bp_count", 1024'(phv_count), 1024'd3);

    // back-to-back with ready_in high
    for (int k = 0; k < 10; k++) begin
      drive(48'h5000 + 48'(k*16), 32'h6000, 16'h7000, 256'(100+k));
      @(negedge clk);
      chk($sformatf("b2b_rdy%0d", k), 1024'(ready_out), 1024'd1);
      chk($sformatf("b2b_phv%0d", k), phv_out,
          mk(48'h5000 + 48'(k*16), 32'h6000, 16'h7000, 256'(100+k)));
    end
    alu_out_valid = 1'b0;
    @(negedge clk);
    chk("b2b_empty", 1024'(phv_out_valid), 1024'd0);
    chk("b2b_count", 1024'(phv_count), 1024'd13);
    chk("b2b_ovf", 1024'(overflow_err), 1024'd0);

    // overflow
    ready_in = 1'b0;
    exp_c = mk(48'hCCC0, 32'hCCC0, 16'hCCC0, 256'hC);
    drive(48'h1000, 32'h2000, 16'h3000, 256'h1);
    @(negedge clk);
    drive(48'h1100, 32'h2100, 16'h3100, 256'h2);
    @(negedge clk);
    drive(48'hCCC0, 32'hCCC0, 16'hCCC0, 256'hC);
    @(negedge clk);
    alu_out_valid = 1'b0;
    chk("ov_err", 1024'(overflow_err), 1024'd1);
    chk("ov_head", phv_out, exp_a);
    ready_in = 1'b1;
    @(negedge clk);
    chk("ov_b", phv_out, exp_b);
    @(negedge clk);
    chk("ov_empty", 1024'(phv_out_valid), 1024'd0);
    chk("ov_sticky", 1024'(overflow_err), 1024'd1);
    chk("ov_count", 1024'(phv_count), 1024'd15);

    // counter wrap
    ready_in = 1'b0;
    drive(48'h9000, 32'h9000, 16'h9000, 256'h9);
    @(negedge clk);
    alu_out_valid = 1'b0;
    force dut.phv_count = 32'hFFFF_FFFF;
    #1;
    release dut.phv_count;
    chk("wr_pre", 1024'(phv_count), 1024'hFFFF_FFFF);
    ready_in = 1'b1;
    @(negedge clk);
    chk("wr_zero", 1024'(phv_count), 1024'd0);

    // reset with the buffer full
    ready_in = 1'b0;
    drive(48'h1000, 32'h2000, 16'h3000, 256'h1);
    @(negedge clk);
    drive(48'h1100, 32'h2100, 16'h3100, 256'h2);
    @(negedge clk);
    alu_out_valid = 1'b0;
    chk("mr_full", 1024'(ready_out), 1024'd0);
    rst = 1'b1;
    ready_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_valid", 1024'(phv_out_valid), 1024'd0);
    chk("mr_ready", 1024'(ready_out), 1024'd1);
    chk("mr_count", 1024'(phv_count), 1024'd0);
    chk("mr_ovf", 1024'(overflow_err), 1024'd0);
    chk("mr_phv", phv_out, 1024'd0);
    @(negedge clk);
    chk("mr_idle", 1024'(phv_out_valid), 1024'd0);
    drive(48'h600, 32'h400, 16'h200, 256'hABCD);
    @(negedge clk);
    alu_out_valid = 1'b0;
    chk("mr_again", phv_out, mk(48'h600, 32'h400, 16'h200, 256'hABCD));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
